// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit with PC ownership, valid/ready core handoff and sticky fault
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        commit_valid,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        fetch_fault,
  output logic [31:0] retired_cnt
);
  typedef enum logic [2:0] {REQ, WAIT, VALID, EXEC, FAULT} state_t;
  state_t state;
  logic [31:0] wd;
  assign imem_req_valid = state == REQ;
  assign imem_req_addr = pc;
  assign inst_valid = state == VALID;
  assign fetch_fault = state == FAULT;
  always_ff @(posedge clk)
    if (reset) begin
      state <= REQ;
      pc <= RESET_PC;
      inst <= '0;
      inst_pc <= '0;
      retired_cnt <= '0;
      wd <= '0;
    end else
      case (state)
        REQ: if (imem_req_ready) begin
          state <= WAIT;
          wd <= '0;
        end
        WAIT: if (imem_resp_valid) begin
          inst <= imem_resp_data;
          inst_pc <= pc;
          state <= VALID;
        end else begin
          wd <= wd + 32'd1;
          if (TIMEOUT != 0 && wd + 32'd1 == 32'(TIMEOUT)) state <= FAULT;
        end
        VALID: if (inst_ready) state <= EXEC;
        EXEC: if (commit_valid) begin
          pc <= next_pc;
          retired_cnt <= retired_cnt + 32'd1;
          state <= next_pc[1:0] == 2'b00 ? REQ : FAULT;
        end
        default: state <= FAULT;
      endcase
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench with a memory model, a core model and a queue-based fetch reference
module tb_ifu_fetch;
  localparam logic [31:0] RPC = 32'h80000000;
  logic clk, reset, imem_req_valid, imem_req_ready, imem_resp_valid, inst_valid, inst_ready, commit_valid, fetch_fault;
  logic [31:0] imem_req_addr, imem_resp_data, inst, inst_pc, next_pc, pc, retired_cnt;
  typedef struct {logic [31:0] a; logic [31:0] b;} pair_t;
  pair_t req_q[$], inst_q[$], dq;
  logic [31:0] np_q[$];
  logic [31:0] exp_pc, exp_ret, mem_addr, fire_addr;
  int total, passed, n_req, n_inst, n0, mem_cnt, mem_delay, rdy_p, ir_p, cv_p, spur_p;
  bit fire_q, executing, rand_delay;

  ifu_fetch #(.RESET_PC(RPC), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .commit_valid(commit_valid), .next_pc(next_pc), .pc(pc),
    .fetch_fault(fetch_fault), .retired_cnt(retired_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", n, act, exp);
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a == RPC ? 32'h00000413 : (a * 32'h9e3779b1) ^ 32'h00000013;
  endfunction

  task automatic model_commit(input logic [31:0] np);
    exp_ret++;
    exp_pc = np;
    if (np[1:0] == 2'b00) begin
      req_q.push_back('{np, exp_ret});
      inst_q.push_back('{mem_fn(np), np});
    end
  endtask

  task automatic model_reset();
    req_q.delete();
    inst_q.delete();
    exp_ret = 0;
    exp_pc = RPC;
    req_q.push_back('{RPC, 32'd0});
    inst_q.push_back('{mem_fn(RPC), RPC});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fire_q) begin
      if (rand_delay) mem_delay = $urandom_range(4, 1);
      mem_cnt = mem_delay;
      mem_addr = fire_addr;
      fire_q = 0;
    end else if (mem_cnt > 0) mem_cnt--;
    imem_resp_valid = mem_cnt == 1;
    imem_resp_data = imem_resp_valid ? mem_fn(mem_addr) : $urandom;
    imem_req_ready = $urandom_range(99) < rdy_p;
    inst_ready = $urandom_range(99) < ir_p;
    commit_valid = 0;
    next_pc = $urandom;
    if (executing && $urandom_range(99) < cv_p) begin
      if (np_q.size() > 0) next_pc = np_q.pop_front();
      else if ($urandom_range(3) == 0) next_pc = {16'h8000, 14'($urandom), 2'b00};
      else next_pc = exp_pc + 32'd4;
      commit_valid = 1;
      executing = 0;
      model_commit(next_pc);
    end else if (!executing && $urandom_range(99) < spur_p) commit_valid = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    executing = 0;
    repeat (2) step();
    fire_q = 0;
    mem_cnt = 0;
    imem_resp_valid = 0;
    np_q.delete();
    model_reset();
    reset = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("req_expected", 32'(imem_req_valid && req_q.size() == 0), 32'd0);
      if (imem_req_valid && req_q.size() > 0) begin
        chk("req_addr", imem_req_addr, req_q[0].a);
        chk("pc", pc, req_q[0].a);
        chk("retired_cnt", retired_cnt, req_q[0].b);
        if (imem_req_ready) dq = req_q.pop_front();
      end
      if (imem_req_valid && imem_req_ready) begin
        fire_q = 1;
        fire_addr = imem_req_addr;
        n_req++;
      end
      chk("inst_expected", 32'(inst_valid && inst_q.size() == 0), 32'd0);
      if (inst_valid && inst_q.size() > 0) begin
        chk("inst", inst, inst_q[0].a);
        chk("inst_pc", inst_pc, inst_q[0].b);
        if (inst_ready) dq = inst_q.pop_front();
      end
      if (inst_valid && inst_ready) begin
        executing = 1;
        n_inst++;
      end
      chk("req_and_inst_exclusive", 32'(imem_req_valid && inst_valid), 32'd0);
    end
  end

  initial begin
    total = 0; passed = 0; n_req = 0; n_inst = 0; mem_cnt = 0; fire_q = 0; executing = 0; rand_delay = 0;
    reset = 1; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0; inst_ready = 0; commit_valid = 0; next_pc = 0;
    rdy_p = 100; ir_p = 100; cv_p = 100; spur_p = 0; mem_delay = 1;
    do_reset();
    np_q.push_back(32'h80000004);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_addr", imem_req_addr, RPC);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    step(); @(negedge clk);
    chk("lat_n1_inst_valid", 32'(inst_valid), 32'd0);
    step(); @(negedge clk);
    chk("lat_n2_inst_valid", 32'(inst_valid), 32'd1);
    chk("lat_n2_inst", inst, 32'h00000413);
    chk("lat_n2_inst_pc", inst_pc, RPC);
    step(); @(negedge clk);
    chk("exec_req_valid", 32'(imem_req_valid), 32'd0);
    chk("exec_inst_valid", 32'(inst_valid), 32'd0);
    step(); @(negedge clk);
    chk("next_req_valid", 32'(imem_req_valid), 32'd1);
    chk("next_req_addr", imem_req_addr, 32'h80000004);
    chk("next_retired", retired_cnt, 32'd1);

    rdy_p = 0; ir_p = 0; cv_p = 0;
    do_reset();
    n0 = n_req;
    step(); step(); @(negedge clk);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
    chk("stall_req_addr", imem_req_addr, RPC);
    rdy_p = 100; step(); rdy_p = 0;
    repeat (3) step();
    @(negedge clk);
    chk("bp_inst_valid", 32'(inst_valid), 32'd1);
    chk("bp_inst", inst, 32'h00000413);
    chk("bp_inst_pc", inst_pc, RPC);
    ir_p = 100; step(); ir_p = 0;
    repeat (3) step();
    @(negedge clk);
    chk("bp_one_request", 32'(n_req - n0), 32'd1);
    chk("bp_exec_inst_valid", 32'(inst_valid), 32'd0);

    np_q.push_back(32'h80000100);
    cv_p = 100; spur_p = 100; rdy_p = 100; mem_delay = 3;
    repeat (7) step();
    @(negedge clk);
    chk("jump_pc", pc, 32'h80000100);
    chk("jump_retired", retired_cnt, 32'd1);
    chk("jump_inst_valid", 32'(inst_valid), 32'd1);
    chk("jump_inst_pc", inst_pc, 32'h80000100);
    chk("jump_inst", inst, mem_fn(32'h80000100));

    spur_p = 0; ir_p = 100;
    np_q.push_back(32'h80000102);
    repeat (3) step();
    @(negedge clk);
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_pc", pc, 32'h80000102);
    chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mis_inst_valid", 32'(inst_valid), 32'd0);
    chk("mis_retired", retired_cnt, 32'd2);
    repeat (5) step();
    @(negedge clk);
    chk("mis_fault_sticky", 32'(fetch_fault), 32'd1);
    chk("mis_pc_hold", pc, 32'h80000102);
    chk("mis_req_valid_hold", 32'(imem_req_valid), 32'd0);
    mem_delay = 1;
    do_reset();
    @(negedge clk);
    chk("mis_rst_fault", 32'(fetch_fault), 32'd0);
    chk("mis_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("mis_rst_addr", imem_req_addr, RPC);

    mem_delay = 0;
    do_reset();
    repeat (4) step();
    @(negedge clk);
    chk("to_wait4_fault", 32'(fetch_fault), 32'd0);
    step(); @(negedge clk);
    chk("to_fault", 32'(fetch_fault), 32'd1);
    chk("to_pc", pc, RPC);
    chk("to_req_valid", 32'(imem_req_valid), 32'd0);
    mem_delay = 4; ir_p = 0;
    do_reset();
    repeat (5) step();
    @(negedge clk);
    chk("late_fault", 32'(fetch_fault), 32'd0);
    chk("late_inst_valid", 32'(inst_valid), 32'd1);
    chk("late_inst", inst, 32'h00000413);

    ir_p = 100; cv_p = 100; mem_delay = 2;
    do_reset();
    np_q.push_back(32'h80000010);
    repeat (6) step();
    @(negedge clk);
    chk("prewait_retired", retired_cnt, 32'd1);
    chk("prewait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("prewait_inst_valid", 32'(inst_valid), 32'd0);
    do_reset();
    @(negedge clk);
    chk("rwait_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rwait_inst_valid", 32'(inst_valid), 32'd0);
    chk("rwait_retired", retired_cnt, 32'd0);
    chk("rwait_addr", imem_req_addr, RPC);
    ir_p = 0;
    repeat (3) step();
    @(negedge clk);
    chk("prevalid_inst_valid", 32'(inst_valid), 32'd1);
    do_reset();
    @(negedge clk);
    chk("rvalid_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rvalid_inst_valid", 32'(inst_valid), 32'd0);
    chk("rvalid_addr", imem_req_addr, RPC);

    rdy_p = 60; ir_p = 60; cv_p = 50; spur_p = 20; rand_delay = 1;
    do_reset();
    n0 = n_inst;
    repeat (3000) step();
    @(negedge clk);
    chk("random_progress", 32'(n_inst - n0 > 100), 32'd1);
    chk("random_no_fault", 32'(fetch_fault), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit that sits directly upstream of the single-cycle decode/execute core. It owns the PC. It fetches one instruction per retire over a valid/ready instruction-memory bus, with one request outstanding at a time. It presents the instruction and its PC to the core with a valid/ready handshake, and advances only when the core commits a next PC. Misaligned next PCs and memory response timeouts latch a sticky fault.

Parameters:
RESET_PC, 32'h80000000, PC loaded on reset.
TIMEOUT, 255, maximum cycles spent in WAIT before fault; 0 disables the watchdog.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  32  fetch address; always equals pc.
imem_req_ready  input  1  memory accepts the request.
imem_resp_valid  input  1  read data valid.
imem_resp_data  input  32  instruction word.
inst_valid  output  1  inst/inst_pc valid to the core.
inst  output  32  fetched instruction, registered.
inst_pc  output  32  PC of inst.
inst_ready  input  1  core accepts inst.
commit_valid  input  1  core retired the current instruction; next_pc is valid.
next_pc  input  32  PC computed by the core (jal/jalr/pc+4).
pc  output  32  current PC register.
fetch_fault  output  1  sticky fault flag.
retired_cnt  output  32  count of commits accepted.

Behaviour:
- Reset (takes priority over everything):
  - state=REQ, pc=RESET_PC, inst=0, inst_pc=0, fetch_fault=0, retired_cnt=0, watchdog count=0.
  - All outputs are registered or derived from state. imem_req_valid=1 in the first cycle after reset deasserts.
- States: REQ, WAIT, VALID, EXEC, FAULT.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready -> WAIT and clear the watchdog.
  - The request must hold stable while ready is low.
- WAIT:
  - imem_resp_valid is sampled only in this state; in every other state it is ignored.
  - On imem_resp_valid: inst<=imem_resp_data, inst_pc<=pc, -> VALID.
  - Otherwise the watchdog increments. If TIMEOUT!=0 and the watchdog reaches TIMEOUT with no response, -> FAULT.
  - A response arriving in the same cycle as the final watchdog count wins: the fetch completes, no fault.
- VALID:
  - inst_valid=1; inst and inst_pc stay stable until the handshake.
  - On inst_ready -> EXEC.
- EXEC:
  - inst_valid=0. The fetch unit waits for commit_valid.
  - On commit_valid: pc<=next_pc, retired_cnt<=retired_cnt+1 (wraps mod 2^32).
  - If next_pc[1:0]==0 -> REQ; else fetch_fault<=1 -> FAULT.
- commit_valid outside EXEC is ignored: no pc change, no count.
- FAULT:
  - fetch_fault=1, imem_req_valid=0, inst_valid=0.
  - The state holds until reset. pc holds the offending value (misaligned next_pc, or the address that timed out).
- Latency:
  - Request accepted in cycle N gives the earliest response in N+1 and inst_valid in N+2.
  - Commit in cycle M gives imem_req_valid in M+1.
  - Best-case fetch-to-fetch period is 4 cycles with zero memory wait.
- Only one request is ever outstanding.
- Reset mid-fetch abandons the in-flight request. The memory side is reset by the same reset, and a stale response is not delivered.

Test Plan:
- Reset then idle memory (req_ready=1, response one cycle later with 32'h00000413): imem_req_addr=32'h80000000 in the first cycle after reset; inst_valid at +2 with inst=32'h00000413, inst_pc=32'h80000000; commit next_pc=32'h80000004 -> next request addr 32'h80000004, retired_cnt=1.
- Backpressure (req_ready low 3 cycles, inst_ready low 2 cycles): imem_req_addr is stable across the stall; inst/inst_pc do not change while inst_valid=1 and inst_ready=0; exactly one request issued.
- Jump commit next_pc=32'h80000100 (jal) -> pc=32'h80000100 and the next request uses it; spurious commit_valid pulses during WAIT and VALID change neither pc nor retired_cnt.
- Misaligned commit next_pc=32'h80000102 -> fetch_fault=1 the next cycle, pc=32'h80000102, no further imem_req_valid; then reset -> fault clears, fetch restarts at 32'h80000000.
- Timeout with TIMEOUT=4 and no response -> FAULT exactly 4 cycles after entering WAIT. Separately, a response in the 4th WAIT cycle -> no fault, inst_valid asserts.
- Reset asserted in WAIT and again in VALID: the next cycle has state REQ, inst_valid=0, retired_cnt=0, imem_req_addr=32'h80000000.
